// File: rtl/sdram_burst_prefetch.sv
// sdram_burst_prefetch: splits one read request into fixed SDRAM bursts and streams the beats into a FIFO write port.
// Define BYTE_SWAP_EN to byte-swap every 16-bit lane of the FIFO write data.
module sdram_burst_prefetch #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 12,
  parameter int FREE_W    = 11
) (
  input  logic              sdram_clk,
  input  logic              rst_n,
  input  logic              i_req_async,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_abort_async,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_avalid,
  input  logic              i_rd_aready,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  output logic              o_fifo_wen,
  output logic [DATA_W-1:0] o_fifo_wdata,
  input  logic [FREE_W-1:0] i_fifo_free
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_req_sync;
  logic [2:0]       r_abort_sync;
  logic             r_req_edge;
  logic             r_abort_edge;
  logic             r_abort_pend;
  logic [LEN_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_burst_words;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_bw;
  logic             w_room;

  assign w_bw       = (32'(r_remaining) < BURST_LEN) ? CNT_W'(r_remaining) : CNT_W'(BURST_LEN);
  assign w_room     = 32'(i_fifo_free) >= 32'(w_bw);
  // The controller always returns a full burst; surplus beats of a short final burst are dropped here.
  assign o_fifo_wen = i_rd_valid & o_rd_ready & (r_beat_cnt < r_burst_words);

`ifdef BYTE_SWAP_EN
  for (genvar l = 0; l < DATA_W / 16; l++) begin : g_swap
    assign o_fifo_wdata[16*l +: 16] = {i_rd_data[16*l +: 8], i_rd_data[16*l+8 +: 8]};
  end
`else
  assign o_fifo_wdata = i_rd_data;
`endif

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync   <= '0;
      r_abort_sync <= '0;
      r_req_edge   <= 1'b0;
      r_abort_edge <= 1'b0;
    end else begin
      r_req_sync   <= {r_req_sync[1:0], i_req_async};
      r_abort_sync <= {r_abort_sync[1:0], i_abort_async};
      r_req_edge   <= r_req_sync[1] & ~r_req_sync[2];
      r_abort_edge <= r_abort_sync[1] & ~r_abort_sync[2];
    end
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_abort_pend  <= 1'b0;
      r_remaining   <= '0;
      r_burst_words <= '0;
      r_beat_cnt    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rd_addr     <= '0;
      o_rd_avalid   <= 1'b0;
      o_rd_ready    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (r_abort_edge && r_state != IDLE) r_abort_pend <= 1'b1;
      case (r_state)
        IDLE: if (r_req_edge) begin
          o_rd_addr   <= i_req_addr;
          r_remaining <= i_req_len;
          o_busy      <= 1'b1;
          r_state     <= CHECK;
        end
        CHECK: if (r_abort_pend || r_remaining == '0) begin
          o_done  <= 1'b1;
          r_state <= DONE;
        end else if (w_room) begin
          r_burst_words <= w_bw;
          o_rd_avalid   <= 1'b1;
          r_state       <= ADDR;
        end
        ADDR: if (i_rd_aready) begin
          o_rd_avalid <= 1'b0;
          o_rd_ready  <= 1'b1;
          r_beat_cnt  <= '0;
          r_state     <= DATA;
        end
        DATA: if (i_rd_valid) begin
          if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            o_rd_addr   <= o_rd_addr + ADDR_W'(BURST_LEN);
            r_remaining <= r_remaining - LEN_W'(r_burst_words);
            o_rd_ready  <= 1'b0;
            r_state     <= CHECK;
          end else begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          o_busy       <= 1'b0;
          r_abort_pend <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burst_prefetch.sv
// tb_sdram_burst_prefetch: randomized controller/FIFO environment checked against a transfer-level model.
`timescale 1ns/1ps
module tb_sdram_burst_prefetch;
  localparam int AW = 22, DW = 16, BL = 4, LW = 12, FW = 11;
  localparam logic [AW-1:0] AMASK = '1;

  logic          sdram_clk = 1'b0, rst_n = 1'b0;
  logic          i_req_async = 1'b0, i_abort_async = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [LW-1:0] i_req_len = '0;
  logic [FW-1:0] i_fifo_free = '0;
  logic          o_busy, o_done, o_rd_avalid, o_rd_ready, o_fifo_wen;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] o_fifo_wdata;
  logic          i_rd_aready, i_rd_valid;
  logic [DW-1:0] i_rd_data;

  logic          auto = 1'b1;
  logic          c_aready, c_valid, m_aready = 1'b0, m_valid = 1'b0;
  logic [DW-1:0] c_data, m_data = '0;
  int            gap_min = 0, tests = 0, fails = 0, done_cnt = 0;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_w[$], sent_q[$];

  assign i_rd_aready = auto ? c_aready : m_aready;
  assign i_rd_valid  = auto ? c_valid : m_valid;
  assign i_rd_data   = auto ? c_data : m_data;

  always #5 sdram_clk = ~sdram_clk;

  sdram_burst_prefetch #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .LEN_W(LW), .FREE_W(FW)) dut (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .i_req_async(i_req_async), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .i_abort_async(i_abort_async), .o_busy(o_busy), .o_done(o_done),
    .o_rd_addr(o_rd_addr), .o_rd_avalid(o_rd_avalid), .i_rd_aready(i_rd_aready), .i_rd_data(i_rd_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .o_fifo_wen(o_fifo_wen), .o_fifo_wdata(o_fifo_wdata),
    .i_fifo_free(i_fifo_free)
  );

  function automatic logic [DW-1:0] exp_w(input logic [DW-1:0] d);
`ifdef BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge sdram_clk) if (o_done) done_cnt++;

  // Controller model: accepts each address after a random delay and returns a full burst with random gaps.
  initial begin
    c_aready = 1'b0;
    c_valid  = 1'b0;
    c_data   = '0;
    forever begin
      @(negedge sdram_clk);
      if (auto && rst_n && o_rd_avalid) begin
        repeat ($urandom_range(0, 2)) @(negedge sdram_clk);
        c_aready = 1'b1;
        got_addr.push_back(o_rd_addr);
        @(negedge sdram_clk);
        c_aready = 1'b0;
        for (int b = 0; b < BL; b++) begin
          repeat (gap_min + $urandom_range(0, 1)) @(negedge sdram_clk);
          c_valid = 1'b1;
          c_data  = DW'($urandom);
          sent_q.push_back(c_data);
          #1;
          if (o_fifo_wen) got_w.push_back(o_fifo_wdata);
          @(negedge sdram_clk);
          c_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge sdram_clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 0, 1);
  endtask

  task automatic wait_sent(input int k);
    int n = 0;
    while (sent_q.size() < k && n < 500) begin
      @(negedge sdram_clk);
      n++;
    end
    if (sent_q.size() < k) check("beat_timeout", 0, 1);
  endtask

  task automatic clear_q();
    got_addr.delete();
    got_w.delete();
    sent_q.delete();
  endtask

  // Transfer-level model: ceil(len/BL) bursts at addr+i*BL (mod 2^AW), first len beats reach the FIFO;
  // an abort in the first burst leaves exactly that burst.
  task automatic finish_req(input logic [AW-1:0] addr, input int len, input bit abort, input int d0);
    int nb, nw;
    nb = abort ? 1 : (len + BL - 1) / BL;
    nw = abort ? (len < BL ? len : BL) : len;
    wait_done(d0 + 1);
    @(negedge sdram_clk);
    check("busy_after_done", 32'(o_busy), 0);
    i_req_async   = 1'b0;
    i_abort_async = 1'b0;
    repeat (40) @(negedge sdram_clk);
    check("done_count", 32'(done_cnt - d0), 1);
    check("bursts", 32'(got_addr.size()), 32'(nb));
    check("writes", 32'(got_w.size()), 32'(nw));
    for (int i = 0; i < got_addr.size() && i < nb; i++)
      check($sformatf("addr%0d", i), 32'(got_addr[i]), 32'((addr + AW'(i * BL)) & AMASK));
    for (int i = 0; i < got_w.size() && i < nw && i < sent_q.size(); i++)
      check($sformatf("wdata%0d", i), 32'(got_w[i]), 32'(exp_w(sent_q[i])));
  endtask

  task automatic run_req(input logic [AW-1:0] addr, input int len, input int free, input bit retrig, input bit abort);
    int d0 = done_cnt;
    clear_q();
    i_fifo_free = FW'(free);
    i_req_addr  = addr;
    i_req_len   = LW'(len);
    @(negedge sdram_clk);
    i_req_async = 1'b1;
    if (retrig) begin
      wait_sent(1);
      i_req_async = 1'b0;
      repeat (4) @(negedge sdram_clk);
      i_req_async = 1'b1;
    end
    if (abort) begin
      wait_sent(2);
      i_abort_async = 1'b1;
    end
    finish_req(addr, len, abort, d0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge sdram_clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_avalid", 32'(o_rd_avalid), 0);
    check("rst_ready", 32'(o_rd_ready), 0);
    check("rst_wen", 32'(o_fifo_wen), 0);
    check("rst_addr", 32'(o_rd_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sdram_clk);

    run_req(22'h000100, 8, 512, 0, 0);
    run_req(22'h000100, 6, 512, 0, 0);
    run_req(22'h3FFFFE, 8, 512, 1, 0);
    gap_min = 3;
    run_req(22'h001000, 16, 512, 0, 1);
    gap_min = 0;
    run_req(22'h000040, 0, 512, 0, 0);

    // Back-pressure: space for less than a burst keeps the address phase off.
    clear_q();
    d0 = done_cnt;
    auto = 1'b0;
    i_fifo_free = 11'd3;
    i_req_addr = 22'h000200;
    i_req_len = 12'd8;
    i_req_async = 1'b1;
    repeat (12) @(negedge sdram_clk);
    check("bp_avalid_low", 32'(o_rd_avalid), 0);
    check("bp_busy", 32'(o_busy), 1);
    i_fifo_free = 11'd4;
    @(negedge sdram_clk);
    check("bp_avalid_rise", 32'(o_rd_avalid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge sdram_clk);
      check("hold_avalid", 32'(o_rd_avalid), 1);
      check("hold_addr", 32'(o_rd_addr), 32'h200);
    end
    auto = 1'b1;
    finish_req(22'h000200, 8, 0, d0);

    for (int t = 0; t < 12; t++)
      run_req(AW'($urandom) & AMASK, $urandom_range(0, 20), $urandom_range(BL, 600), 0, 0);

    // Reset in the middle of a data phase.
    auto = 1'b0;
    i_fifo_free = 11'd512;
    i_req_addr = 22'h000010;
    i_req_len = 12'd8;
    i_req_async = 1'b1;
    for (int n = 0; n < 100 && !o_rd_avalid; n++) @(negedge sdram_clk);
    check("rst_test_avalid", 32'(o_rd_avalid), 1);
    m_aready = 1'b1;
    @(negedge sdram_clk);
    m_aready = 1'b0;
    m_valid = 1'b1;
    m_data = 16'h12AB;
    #1;
    check("mid_wen", 32'(o_fifo_wen), 1);
    check("swap_wdata", 32'(o_fifo_wdata), 32'(exp_w(16'h12AB)));
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 0);
    check("arst_avalid", 32'(o_rd_avalid), 0);
    check("arst_ready", 32'(o_rd_ready), 0);
    check("arst_wen", 32'(o_fifo_wen), 0);
    @(negedge sdram_clk);
    m_valid = 1'b0;
    i_req_async = 1'b0;
    rst_n = 1'b1;
    auto = 1'b1;
    repeat (5) @(negedge sdram_clk);
    run_req(22'h000300, 5, 512, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdram_burst_prefetch.md
Name: sdram_burst_prefetch

Overview:
Multi-burst SDRAM read engine. It takes a single request (start address plus word count) and splits it into fixed-length bursts on the SDRAM controller read port. Returned data is pushed into a downstream async FIFO write port, and a new burst is issued only when the FIFO has room. Generalises the single-burst read-to-FIFO path with:
- parametrised widths and burst length
- variable transfer length
- back-pressure from FIFO free space
- abort

Parameters:
- ADDR_W, 22: SDRAM word address width; rd_addr wraps modulo 2^ADDR_W.
- DATA_W, 16: data width; must be a multiple of 16 when BYTE_SWAP_EN is defined.
- BURST_LEN, 4: beats per controller burst (fixed by controller); range 1..64.
- LEN_W, 12: request length width (words).
- FREE_W, 11: width of FIFO free-space input.

Ports:
- sdram_clk, in, 1: block clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_async, in, 1: request level from foreign domain; rising edge starts a transfer. req_addr/req_len must be stable while high.
- req_addr, in, ADDR_W: start word address.
- req_len, in, LEN_W: words to deliver; 0 means no-op.
- abort_async, in, 1: abort level from foreign domain; rising edge stops the transfer.
- busy, out, 1: high whenever state != IDLE.
- done, out, 1: one-cycle pulse at end of every accepted request (including aborts and no-ops).
- rd_addr, out, ADDR_W: burst start address, registered.
- rd_avalid, out, 1: address valid.
- rd_aready, in, 1: address accepted.
- rd_data, in, DATA_W: read beat.
- rd_valid, in, 1: beat valid.
- rd_ready, out, 1: beat accept.
- fifo_wen, out, 1: FIFO write strobe.
- fifo_wdata, out, DATA_W: FIFO write data.
- fifo_free, in, FREE_W: free FIFO words (sdram_clk domain, may be pessimistic).

Behaviour:
- Reset values: busy=0, done=0, rd_avalid=0, rd_ready=0, fifo_wen=0, rd_addr=0, all counters 0, state IDLE. Reset mid-transfer returns to IDLE immediately; any in-flight controller burst is abandoned.
- Synchronisers: req_async and abort_async each pass through 2 flops plus an edge register; edge = s2 & !s3.
- Request edge in IDLE:
  - captures req_addr into rd_addr and req_len into remaining;
  - goes to CHECK next cycle.
- Request edge while busy is ignored and not queued.
- Abort edge sets abort_pend, which is cleared on entry to IDLE.
- Abort edge in IDLE is ignored.
- FSM states: IDLE, CHECK, ADDR, DATA, DONE.
- CHECK:
  - abort_pend or remaining==0 -> DONE;
  - else fifo_free >= bw -> ADDR, latching bw into burst_words;
  - otherwise stay in CHECK.
  - bw = min(BURST_LEN, remaining), combinational.
- ADDR: rd_avalid=1 and is held until rd_aready (never retracted); then -> DATA with beat_cnt=0.
  - An abort arriving in ADDR does not retract rd_avalid.
- DATA:
  - rd_ready=1; each rd_valid&rd_ready increments beat_cnt.
  - On beat BURST_LEN-1: rd_addr += BURST_LEN (mod 2^ADDR_W), remaining -= burst_words, -> CHECK.
  - An abort in DATA lets the current burst complete, then CHECK routes to DONE.
- DONE: done=1 for one cycle -> IDLE.
- Write path (combinational): fifo_wen = rd_valid & rd_ready & (beat_cnt < burst_words).
  - Beats beyond burst_words in a partial final burst are accepted from the controller and discarded.
  - fifo_wdata = rd_data, optionally byte-swapped.
- Latency: request edge to first rd_avalid is 5 sdram_clk cycles (sync 2, edge 1, IDLE->CHECK 1, CHECK->ADDR 1) when FIFO has space.
- No FIFO overflow is possible if fifo_free is accurate: the space check covers the whole delivered burst.

Optional Feature:
BYTE_SWAP_EN
- Defined: each 16-bit lane of fifo_wdata is byte-swapped ({d[7:0],d[15:8]} per lane), matching QSPI MSB-byte-first output.
- Undefined: fifo_wdata = rd_data unchanged.

Test Plan:
1. addr=0x000100, len=8, fifo_free=512 -> two bursts at rd_addr 0x000100 and 0x000104, 8 fifo_wen pulses with data in controller order, one done pulse, busy low after DONE.
2. len=6 -> second burst at 0x000104 accepts 4 beats, fifo_wen only on the first 2; total 6 writes, done once.
3. len=8, fifo_free=3 -> stays in CHECK with rd_avalid=0; raise fifo_free to 4 -> rd_avalid next cycle; hold rd_aready low 5 cycles -> rd_avalid stays high and rd_addr stable.
4. addr=0x3FFFFE, len=8 -> bursts at 0x3FFFFE and 0x000002 (wrap); second req_async edge while busy ignored (no extra burst, single done).
5. Abort edge during beat 1 of burst 1 of len=16 -> burst 1 completes with 4 writes, no further rd_avalid, done pulse. len=0 -> done pulse, no rd_avalid.
6. rst_n low mid-DATA -> busy, rd_avalid, rd_ready, fifo_wen low immediately. With BYTE_SWAP_EN, rd_data=0x12AB -> fifo_wdata=0xAB12; without it, 0x12AB.
